// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch stage: fetches one word per instruction
// over a req/ack handshake and advances the PC from the control unit's sequencing.
module pc_fetch #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         opcode,
    output logic               instr_valid,
    input  logic               step,
    input  logic               s_inc,
    input  logic               s_skip,
    input  logic               halt,
    output logic [PC_W-1:0]    pc,
    output logic [15:0]        retired,
    output logic               fetch_err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [15:0]        retired_q, retired_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               fetch_err_q, fetch_err_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = retired_q;
        wait_d      = wait_q;
        fetch_err_d = fetch_err_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    wait_d  = '0;
                    state_d = ST_EXEC;
                end else begin
                    // Counter saturates; the error flag is sticky until reset.
                    if (wait_q != WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
                    if (wait_d == WAIT_MAX) fetch_err_d = 1'b1;
                end
            end
            ST_EXEC: begin
                if (step && !halt) begin
                    if (!s_inc)      pc_d = instr_q[PC_W-1:0];
                    else if (s_skip) pc_d = pc_q + PC_W'(2);
                    else             pc_d = pc_q + PC_W'(1);
                    retired_d = retired_q + 16'd1;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            pc_q        <= '0;
            instr_q     <= '0;
            retired_q   <= '0;
            wait_q      <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            retired_q   <= retired_d;
            wait_q      <= wait_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign mem_req     = (state_q == ST_FETCH);
    assign instr_valid = (state_q == ST_EXEC);
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[INSTR_W-1:INSTR_W-6];
    assign retired     = retired_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch with hand-computed expected values.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_req;
    logic [9:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        step = 1'b0;
    logic        s_inc = 1'b0;
    logic        s_skip = 1'b0;
    logic        halt = 1'b0;
    logic [9:0]  pc;
    logic [15:0] retired;
    logic        fetch_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    pc_fetch #(.PC_W(10), .INSTR_W(16), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .step(step), .s_inc(s_inc), .s_skip(s_skip), .halt(halt),
        .pc(pc), .retired(retired), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Call in FETCH: ack at the next edge with the given word.
    task automatic fetch(input logic [15:0] data);
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack   = 1'b0;
    endtask

    task automatic do_step(input logic inc, input logic skip);
        step   = 1'b1;
        s_inc  = inc;
        s_skip = skip;
        tick();
        step   = 1'b0;
        s_inc  = 1'b0;
        s_skip = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_req", 32'(mem_req), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_err", 32'(fetch_err), 0);
        check("rst_instr", 32'(instr), 0);

        reset = 1'b0;
        tick();
        check("boot_req", 32'(mem_req), 1);
        check("boot_addr", 32'(mem_addr), 0);
        fetch(16'hA3C5);
        check("first_instr", 32'(instr), 32'hA3C5);
        check("first_opcode", 32'(opcode), 32'h28);
        check("first_valid", 32'(instr_valid), 1);
        check("first_req_low", 32'(mem_req), 0);

        // Reach pc=5 via two jumps (retired becomes 2).
        do_step(1'b0, 1'b0);
        check("jump_3c5", 32'(pc), 32'h3C5);
        fetch(16'h0005);
        do_step(1'b0, 1'b0);
        check("jump_5", 32'(pc), 5);
        fetch(16'h1111);
        do_step(1'b1, 1'b0);
        check("seq_pc", 32'(pc), 6);
        fetch(16'h2222);
        do_step(1'b1, 1'b1);
        check("skip_pc", 32'(pc), 8);
        fetch(16'h5012);
        do_step(1'b0, 1'b1);
        check("jump_pc", 32'(pc), 32'h012);
        check("retired_5", 32'(retired), 5);

        // Wrap-around, +1 and +2.
        fetch(16'h03FF);
        do_step(1'b0, 1'b0);
        check("pc_3ff_a", 32'(pc), 32'h3FF);
        fetch(16'h0000);
        do_step(1'b1, 1'b0);
        check("wrap_inc", 32'(pc), 0);
        fetch(16'h03FF);
        do_step(1'b0, 1'b0);
        check("pc_3ff_b", 32'(pc), 32'h3FF);
        fetch(16'h0000);
        do_step(1'b1, 1'b1);
        check("wrap_skip", 32'(pc), 1);

        // Timeout: 20 waiting cycles in FETCH at address 1.
        for (int unsigned i = 1; i <= 20; i++) begin
            tick();
            check("to_addr", 32'(mem_addr), 1);
            check("to_req", 32'(mem_req), 1);
            check("to_err", 32'(fetch_err), (i >= 15) ? 32'd1 : 32'd0);
        end
        fetch(16'hBEEF);
        check("late_instr", 32'(instr), 32'hBEEF);
        check("late_valid", 32'(instr_valid), 1);
        check("late_err", 32'(fetch_err), 1);

        // Halt overrides step.
        halt = 1'b1;
        step = 1'b1;
        s_inc = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            check("halt_pc", 32'(pc), 1);
            check("halt_instr", 32'(instr), 32'hBEEF);
            check("halt_retired", 32'(retired), 9);
            check("halt_valid", 32'(instr_valid), 1);
        end
        halt = 1'b0;
        step = 1'b0;
        do_step(1'b1, 1'b0);
        check("unhalt_pc", 32'(pc), 2);
        check("unhalt_retired", 32'(retired), 10);

        // Reset mid-fetch with pc=0x040 and fetch_err set.
        fetch(16'h0040);
        do_step(1'b0, 1'b0);
        check("pre_rst_pc", 32'(pc), 32'h040);
        check("pre_rst_req", 32'(mem_req), 1);
        check("pre_rst_err", 32'(fetch_err), 1);
        #2;
        reset     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 16'h7777;
        #1;
        check("async_req", 32'(mem_req), 0);
        check("async_valid", 32'(instr_valid), 0);
        check("async_err", 32'(fetch_err), 0);
        check("async_pc", 32'(pc), 0);
        check("async_retired", 32'(retired), 0);
        tick();
        check("rst_ack_instr", 32'(instr), 0);
        check("rst_ack_valid", 32'(instr_valid), 0);
        reset   = 1'b0;
        mem_ack = 1'b0;
        #1;
        check("reboot_req", 32'(mem_req), 0);
        tick();
        check("refetch_req", 32'(mem_req), 1);
        check("refetch_addr", 32'(mem_addr), 0);
        check("refetch_instr", 32'(instr), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
